// File: rtl/mldsa_params_pkg.sv
// Shared ML-DSA parameter set (ML-DSA-87 hint dimensions).
package mldsa_params_pkg;

    localparam int unsigned MLDSA_K     = 8;
    localparam int unsigned MLDSA_OMEGA = 75;

endpackage

// File: rtl/sigdecode_h_defines_pkg.sv
// Types shared by the signature h-decoder stages.
package sigdecode_h_defines_pkg;

    localparam int unsigned SDH_BYTE_W = 8;

    typedef enum logic [2:0] {
        SDH_CHK_IDLE,
        SDH_CHK_HSUM,
        SDH_CHK_IDX,
        SDH_CHK_DRAIN,
        SDH_CHK_DONE
    } sdh_chk_state_e;

endpackage

// File: rtl/sigdecode_h_check.sv
// Walks the encoded h string, flags HintBitUnpack malformations and exposes
// per-polynomial hint counts for the downstream bitmap stage.
module sigdecode_h_check
    import sigdecode_h_defines_pkg::*;
#(
    parameter int unsigned MLDSA_K     = mldsa_params_pkg::MLDSA_K,
    parameter int unsigned MLDSA_OMEGA = mldsa_params_pkg::MLDSA_OMEGA,
    parameter int unsigned RD_ADDR_W   = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  zeroize,
    input  logic                  check_start,
    output logic                  hint_rd_en,
    output logic [RD_ADDR_W-1:0]  hint_rd_addr,
    input  logic [SDH_BYTE_W-1:0] hint_rd_data,
    input  logic [3:0]            poly_sel,
    output logic [SDH_BYTE_W-1:0] hintsum_o,
    output logic                  check_busy,
    output logic                  check_done,
    output logic                  sigdecode_h_error
);

    localparam int unsigned KW = (MLDSA_K > 1) ? $clog2(MLDSA_K) : 1;
    localparam int unsigned CW = RD_ADDR_W;

    typedef logic [MLDSA_K-1:0][SDH_BYTE_W-1:0] cum_t;

    sdh_chk_state_e        state_q;
    logic [CW-1:0]         cnt_q;
    logic                  rd_en_q;
    logic [CW-1:0]         rd_addr_q;
    logic                  done_q;
    logic                  err_q;
    cum_t                  cum_q;
    logic [SDH_BYTE_W-1:0] prev_q;
    logic                  rsp_valid_q;
    logic [CW-1:0]         rsp_addr_q;

    logic [MLDSA_K-1:0]    hsum_hit;
    logic                  rsp_is_hsum;
    logic                  rsp_is_idx;
    logic [SDH_BYTE_W-1:0] hsum_lo;
    logic [SDH_BYTE_W-1:0] idx_j;
    logic [SDH_BYTE_W-1:0] total;
    logic [KW-1:0]         idx_p;
    logic [SDH_BYTE_W-1:0] start_p;
    logic                  hsum_bad;
    logic                  idx_bad;
    logic                  bad;
    logic [SDH_BYTE_W-1:0] hintsum;

    // Lowest polynomial whose cumulative count exceeds j; empty polys never win.
    function automatic logic [KW-1:0] locate_poly(input cum_t c, input logic [SDH_BYTE_W-1:0] j);
        logic [KW-1:0] p;
        p = '0;
        for (int k = MLDSA_K - 1; k >= 0; k--) begin
            if (c[k] > j) p = KW'(k);
        end
        return p;
    endfunction

    always_comb begin
        logic [SDH_BYTE_W-1:0] lo;
        hsum_hit = '0;
        hsum_lo  = '0;
        lo       = '0;
        for (int k = 0; k < MLDSA_K; k++) begin
            if (rsp_valid_q && (rsp_addr_q == CW'(MLDSA_OMEGA + k))) begin
                hsum_hit[k] = 1'b1;
                hsum_lo     = lo;
            end
            lo = cum_q[k];
        end
    end

    assign rsp_is_hsum = |hsum_hit;
    assign rsp_is_idx  = rsp_valid_q && (rsp_addr_q < CW'(MLDSA_OMEGA));
    assign idx_j       = SDH_BYTE_W'(rsp_addr_q);
    assign total       = cum_q[MLDSA_K-1];
    assign idx_p       = locate_poly(cum_q, idx_j);

    always_comb begin
        logic [SDH_BYTE_W-1:0] lo;
        start_p = '0;
        lo      = '0;
        for (int k = 0; k < MLDSA_K; k++) begin
            if (idx_p == KW'(k)) start_p = lo;
            lo = cum_q[k];
        end
    end

    assign hsum_bad = rsp_is_hsum &&
                      ((hint_rd_data > SDH_BYTE_W'(MLDSA_OMEGA)) || (hint_rd_data < hsum_lo));
    // First index of each poly has no predecessor to compare against.
    assign idx_bad  = rsp_is_idx &&
                      (((idx_j < total) && (idx_j > start_p) && (hint_rd_data <= prev_q)) ||
                       ((idx_j >= total) && (hint_rd_data != '0)));
    assign bad      = hsum_bad || idx_bad;

    always_comb begin
        logic [SDH_BYTE_W-1:0] lo;
        hintsum = '0;
        lo      = '0;
        for (int k = 0; k < MLDSA_K; k++) begin
            if (int'(poly_sel) == k) hintsum = cum_q[k] - lo;
            lo = cum_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || zeroize) begin
            state_q     <= SDH_CHK_IDLE;
            cnt_q       <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cum_q       <= '0;
            prev_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
        end else begin
            // A read issued in the error cycle is dropped when its byte returns.
            rsp_valid_q <= rd_en_q && !bad;
            rsp_addr_q  <= rd_addr_q;
            for (int k = 0; k < MLDSA_K; k++) begin
                if (hsum_hit[k]) cum_q[k] <= hint_rd_data;
            end
            if (rsp_is_idx) prev_q <= hint_rd_data;

            if (bad) begin
                state_q   <= SDH_CHK_DONE;
                cnt_q     <= '0;
                rd_en_q   <= 1'b0;
                rd_addr_q <= '0;
                done_q    <= 1'b1;
                err_q     <= 1'b1;
            end else begin
                case (state_q)
                    SDH_CHK_IDLE: begin
                        if (check_start) begin
                            state_q   <= SDH_CHK_HSUM;
                            cnt_q     <= '0;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= CW'(MLDSA_OMEGA);
                            err_q     <= 1'b0;
                            cum_q     <= '0;
                            prev_q    <= '0;
                        end
                    end
                    SDH_CHK_HSUM: begin
                        if (cnt_q == CW'(MLDSA_K - 1)) begin
                            state_q   <= SDH_CHK_IDX;
                            cnt_q     <= '0;
                            rd_addr_q <= '0;
                        end else begin
                            cnt_q     <= cnt_q + CW'(1);
                            rd_addr_q <= CW'(MLDSA_OMEGA) + cnt_q + CW'(1);
                        end
                    end
                    SDH_CHK_IDX: begin
                        if (cnt_q == CW'(MLDSA_OMEGA - 1)) begin
                            state_q   <= SDH_CHK_DRAIN;
                            cnt_q     <= '0;
                            rd_en_q   <= 1'b0;
                            rd_addr_q <= '0;
                        end else begin
                            cnt_q     <= cnt_q + CW'(1);
                            rd_addr_q <= cnt_q + CW'(1);
                        end
                    end
                    SDH_CHK_DRAIN: begin
                        state_q <= SDH_CHK_DONE;
                        done_q  <= 1'b1;
                    end
                    SDH_CHK_DONE: begin
                        state_q <= SDH_CHK_IDLE;
                        done_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= SDH_CHK_IDLE;
                        rd_en_q <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign hint_rd_en        = rd_en_q;
    assign hint_rd_addr      = rd_addr_q;
    assign hintsum_o         = hintsum;
    assign check_busy        = (state_q != SDH_CHK_IDLE);
    assign check_done        = done_q;
    assign sigdecode_h_error = err_q;

endmodule
